// File: rtl/piezo_pkg.sv
// ============================================================================
// piezo_pkg
// Shared requester indices, tone codes and arbiter state encoding.
// Rev 1.0
// ============================================================================
`default_nettype none

package piezo_pkg;

    localparam int REQ_KEY     = 0;
    localparam int REQ_WRONG   = 1;
    localparam int REQ_SUCCESS = 2;
    localparam int REQ_FAIL    = 3;
    localparam int NUM_REQ     = 4;

    localparam logic [3:0] TONE_SILENT = 4'd0;
    localparam logic [3:0] TONE_KEY    = 4'd8;
    localparam logic [3:0] TONE_WRONG  = 4'd2;
    localparam logic [3:0] TONE_FAIL   = 4'd1;
    localparam logic [3:0] TONE_NOTE0  = 4'd5;

    localparam logic [1:0] LAST_NOTE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Highest set bit wins: fail > success > wrong > key.
    function automatic logic [NUM_REQ-1:0] top_onehot(input logic [NUM_REQ-1:0] v);
        top_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) top_onehot = 4'b0001 << i;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/piezo_ms_timer.sv
// ============================================================================
// piezo_ms_timer
// Loadable millisecond down-counter; expire flags the tick that ends a period.
// Rev 1.0
// ============================================================================
`default_nettype none

module piezo_ms_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic          expire
);

    logic [CW-1:0] r_cnt;

    // Load has priority, so a tick coinciding with a load is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign expire = tick & (r_cnt == CW'(1));

endmodule

`default_nettype wire

// File: rtl/piezo_arbiter.sv
// ============================================================================
// piezo_arbiter
// Fixed-priority time-sharing of the piezo between key/wrong/success/fail.
// Optional abort-on-higher-priority build: define PIEZO_PREEMPT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module piezo_arbiter
    import piezo_pkg::*;
#(
    parameter int KEY_MS   = 50,
    parameter int WRONG_MS = 300,
    parameter int FAIL_MS  = 1000,
    parameter int NOTE_MS  = 150,
    parameter int GAP_MS   = 20,
    parameter int CW       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic [3:0] req,
    output logic       tone_on,
    output logic [3:0] tone_code,
    output logic [3:0] grant,
    output logic       busy,
    output logic [3:0] pending
);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_grant, w_grant_nxt;
    logic [3:0]    r_pending, w_pending_nxt;
    logic [1:0]    r_note, w_note_nxt;
    logic [3:0]    w_pick, w_clear;
    logic          w_load, w_expire, w_preempt;
    logic [CW-1:0] w_load_val;

    function automatic logic [CW-1:0] class_ms(input logic [3:0] g);
        case (g)
            4'b0001: class_ms = CW'(KEY_MS);
            4'b0010: class_ms = CW'(WRONG_MS);
            4'b0100: class_ms = CW'(NOTE_MS);
            default: class_ms = CW'(FAIL_MS);
        endcase
    endfunction

    assign w_pick = top_onehot(r_pending);

`ifdef PIEZO_PREEMPT_EN
    logic [3:0] w_above;
    // Bits strictly above the one-hot grant.
    assign w_above   = ~((r_grant << 1) - 4'd1);
    assign w_preempt = (r_state == ST_PLAY) && ((r_pending & w_above) != 4'b0000);
`else
    assign w_preempt = 1'b0;
`endif

    piezo_ms_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (tick_1ms),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_pending <= '0;
            r_note    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_pending <= w_pending_nxt;
            r_note    <= w_note_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_note_nxt  = r_note;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_clear     = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending != 4'b0000) begin
                    w_state_nxt = ST_PLAY;
                    w_grant_nxt = w_pick;
                    w_note_nxt  = '0;
                    w_load      = 1'b1;
                    w_load_val  = class_ms(w_pick);
                    w_clear     = w_pick;
                end
            end
            ST_PLAY: begin
                if (w_preempt) begin
                    w_grant_nxt = w_pick;
                    w_note_nxt  = '0;
                    w_load      = 1'b1;
                    w_load_val  = class_ms(w_pick);
                    w_clear     = w_pick;
                end else if (w_expire) begin
                    if (r_grant[REQ_SUCCESS] && (r_note != LAST_NOTE)) begin
                        w_note_nxt = r_note + 2'd1;
                        w_load     = 1'b1;
                        w_load_val = CW'(NOTE_MS);
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_grant_nxt = '0;
                        w_note_nxt  = '0;
                        w_load      = 1'b1;
                        w_load_val  = CW'(GAP_MS);
                    end
                end
            end
            ST_GAP: begin
                if (w_expire) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_note_nxt  = '0;
            end
        endcase
        // A new request on its own grant edge survives the clear.
        w_pending_nxt = (r_pending & ~w_clear) | req;
    end

    always_comb begin
        tone_on   = (r_state == ST_PLAY);
        busy      = (r_state != ST_IDLE);
        tone_code = TONE_SILENT;
        if (r_state == ST_PLAY) begin
            case (r_grant)
                4'b0001: tone_code = TONE_KEY;
                4'b0010: tone_code = TONE_WRONG;
                4'b0100: tone_code = TONE_NOTE0 + {2'b00, r_note};
                4'b1000: tone_code = TONE_FAIL;
                default: tone_code = TONE_SILENT;
            endcase
        end
    end

    assign grant   = r_grant;
    assign pending = r_pending;

endmodule

`default_nettype wire
